// File: rtl/divider_iter_pkg.sv
// rtl/divider_iter_pkg.sv - shared multdiv constants and divider FSM encoding
//
// Purpose: constants shared by the iterative divider and its step datapath.
// Contents:
//   DIV_WIDTH   default operand width of the multdiv unit
//   DIV_MIN     most negative two's complement operand (1 followed by zeros)
//   div_state_e divider control states (IDLE, RUN)
package divider_iter_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
//
// Purpose: shifts the next dividend bit into the partial remainder and tries to
// subtract the divisor magnitude; keeps the difference when it is non-negative.
// Ports:
//   rem_i   in  WIDTH+1  current partial remainder R
//   msb_i   in  1        dividend bit shifted in this step
//   bmag_i  in  WIDTH    divisor magnitude |B|
//   rem_o   out WIDTH+1  next partial remainder
//   qbit_o  out 1        quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] bmag_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    localparam int N  = WIDTH + 1;
    localparam int NG = (N + 3) / 4;

    logic [N-1:0] r_shift;
    logic [N-1:0] b_inv;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] c;
    logic [N-1:0] diff;

    // R is shifted left, so its top bit never reaches the next remainder.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_i[WIDTH];

    assign r_shift = {rem_i[WIDTH-1:0], msb_i};
    assign b_inv   = ~{1'b0, bmag_i};
    assign g       = r_shift & b_inv;
    assign p       = r_shift ^ b_inv;

    // Subtractor R' + ~|B| + 1 as 4-bit carry-lookahead groups. Inside a group
    // every carry is formed directly from g/p and the group carry-in; the
    // group generate/propagate pair then produces the next group's carry-in.
    always_comb begin
        logic cg;
        logic acc;
        logic run_p;
        c  = '0;
        cg = 1'b1;
        for (int k = 0; k < NG; k++) begin
            for (int j = 4 * k; j < 4 * k + 4 && j < N; j++) begin
                acc   = 1'b0;
                run_p = 1'b1;
                for (int m = j - 1; m >= 4 * k; m--) begin
                    acc   = acc | (run_p & g[m]);
                    run_p = run_p & p[m];
                end
                c[j] = acc | (run_p & cg);
            end
            acc   = 1'b0;
            run_p = 1'b1;
            for (int m = 4 * k + 3; m >= 4 * k; m--) begin
                if (m < N) begin
                    acc   = acc | (run_p & g[m]);
                    run_p = run_p & p[m];
                end
            end
            cg = acc | (run_p & cg);
        end
    end

    assign diff = p ^ c;

    // A clear sign bit means R' >= |B|: keep the difference, emit a 1.
    assign qbit_o = ~diff[N-1];
    assign rem_o  = qbit_o ? diff : r_shift;

endmodule

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - iterative signed restoring divider for the multdiv unit
//
// Purpose: divides two's complement operands one quotient bit per clock and
// returns the truncated quotient after a fixed WIDTH-cycle latency.
// Ports:
//   clock           in  1      rising-edge clock
//   reset           in  1      synchronous active-high reset
//   data_operandA   in  WIDTH  dividend, sampled when ctrl_DIV=1
//   data_operandB   in  WIDTH  divisor, sampled when ctrl_DIV=1
//   ctrl_DIV        in  1      start pulse; restarts a running operation
//   data_result     out WIDTH  quotient, held until the next completion
//   data_exception  out 1      divide-by-zero or MIN/-1 overflow
//   data_resultRDY  out 1      one-cycle completion pulse
module divider_iter
    import divider_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dq_q;      // dividend shifts out the top, quotient fills the bottom
    logic [WIDTH-1:0] bmag_q;
    logic [WIDTH:0]   rem_q;
    logic             neg_q;
    logic             exc_q;
    logic [WIDTH-1:0] result_q;
    logic             exception_q;
    logic             rdy_q;

    logic [WIDTH:0]   rem_d;
    logic             qbit;
    logic [WIDTH-1:0] dq_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Negation of MIN wraps to MIN, which read unsigned is exactly |MIN|.
    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .msb_i  (dq_q[WIDTH-1]),
        .bmag_i (bmag_q),
        .rem_o  (rem_d),
        .qbit_o (qbit)
    );

    assign dq_d = {dq_q[WIDTH-2:0], qbit};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            bmag_q      <= '0;
            rem_q       <= '0;
            neg_q       <= 1'b0;
            exc_q       <= 1'b0;
            result_q    <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_DIV) begin
                // A start in RUN simply overwrites the running operation.
                state_q <= ST_RUN;
                cnt_q   <= '0;
                dq_q    <= a_mag;
                bmag_q  <= b_mag;
                rem_q   <= '0;
                neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                exc_q   <= (data_operandB == '0) ||
                           ((data_operandA == MIN_VAL) && (data_operandB == '1));
            end else if (state_q == ST_RUN) begin
                rem_q <= rem_d;
                dq_q  <= dq_d;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // The final quotient bit comes from this cycle's step.
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    if (exc_q) begin
                        result_q    <= '0;
                        exception_q <= 1'b1;
                    end else begin
                        result_q    <= neg_q ? -dq_d : dq_d;
                        exception_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_divider_iter.sv
// tb/tb_divider_iter.sv - scoreboard testbench for divider_iter
module tb_divider_iter;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_res_q[$];
    logic         exp_exc_q[$];
    int           exp_due_q[$];

    divider_iter #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic e);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (sb == 0 || (a == MINV && b == '1)) begin
            q = '0;
            e = 1'b1;
        end else begin
            q = W'(sa / sb);
            e = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called just after a clock edge; the start is sampled on the next edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit abort_prev);
        logic [W-1:0] q;
        logic e;
        if (abort_prev && exp_due_q.size() > 0) begin
            void'(exp_res_q.pop_back());
            void'(exp_exc_q.pop_back());
            void'(exp_due_q.pop_back());
        end
        ref_div(a, b, q, e);
        exp_res_q.push_back(q);
        exp_exc_q.push_back(e);
        exp_due_q.push_back(cyc + 1 + W);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        tick(1);
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_due_q.size() > 0 && budget < 200) begin
            tick(1);
            budget++;
        end
        checks++;
        if (exp_due_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", exp_due_q.size());
            exp_res_q.delete();
            exp_exc_q.delete();
            exp_due_q.delete();
        end
        tick(3);
    endtask

    task automatic do_reset_check(input string name);
        reset = 1'b1;
        tick(1);
        check({name, "_result"}, data_result, '0);
        check({name, "_exc"}, {31'b0, data_exception}, '0);
        check({name, "_rdy"}, {31'b0, data_resultRDY}, '0);
        exp_res_q.delete();
        exp_exc_q.delete();
        exp_due_q.delete();
        reset = 1'b0;
    endtask

    // Monitor: compares every ready pulse against the scoreboard head.
    int           last_rdy_cyc = -10;
    logic [W-1:0] last_res = '0;
    always @(negedge clock) begin
        if (!reset) begin
            if (exp_due_q.size() > 0 && exp_due_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ready due %0d now %0d", exp_due_q[0], cyc);
                void'(exp_res_q.pop_front());
                void'(exp_exc_q.pop_front());
                void'(exp_due_q.pop_front());
            end
            if (data_resultRDY) begin
                if (exp_due_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready result %h expected no pulse (cycle %0d)", data_result, cyc);
                end else begin
                    check("ready_latency", W'(cyc), W'(exp_due_q[0]));
                    check("result", data_result, exp_res_q[0]);
                    check("exception", {31'b0, data_exception}, {31'b0, exp_exc_q[0]});
                    void'(exp_res_q.pop_front());
                    void'(exp_exc_q.pop_front());
                    void'(exp_due_q.pop_front());
                end
                last_rdy_cyc = cyc;
                last_res = data_result;
            end else if (cyc == last_rdy_cyc + 1) begin
                check("result_held", data_result, last_res);
            end
            if (cyc == last_rdy_cyc + 1 && (exp_due_q.size() == 0 || exp_due_q[0] != cyc)) begin
                check("ready_one_cycle", {31'b0, data_resultRDY}, '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        tick(3);
        check("reset_result", data_result, '0);
        check("reset_exc", {31'b0, data_exception}, '0);
        check("reset_rdy", {31'b0, data_resultRDY}, '0);
        reset = 1'b0;
        tick(2);

        // Directed sign and boundary cases.
        start(32'd7, 32'd2, 0);                 drain();
        start(32'hFFFF_FFF9, 32'd2, 0);         drain();
        start(32'd7, 32'hFFFF_FFFE, 0);         drain();
        start(32'hFFFF_FFF9, 32'hFFFF_FFFE, 0); drain();
        start(32'd5, 32'd0, 0);                 drain();
        start(MINV, 32'hFFFF_FFFF, 0);          drain();
        start(MINV, 32'd1, 0);                  drain();

        // Abort at iteration 10 and restart.
        start(32'd100, 32'd3, 0);
        tick(9);
        start(32'd50, 32'd5, 1);
        drain();

        // Reset mid-run, then a fresh operation.
        start(32'd1000, 32'd7, 0);
        tick(14);
        do_reset_check("midrun_reset");
        tick(40);
        start(32'd9, 32'd3, 0);                 drain();

        // Reset together with a start: no operation may begin.
        reset = 1'b1;
        ctrl_DIV = 1'b1;
        data_operandA = 32'd8;
        data_operandB = 32'd2;
        tick(1);
        ctrl_DIV = 1'b0;
        reset = 1'b0;
        check("reset_and_start_rdy", {31'b0, data_resultRDY}, '0);
        tick(40);

        // Back-to-back: next start issued during the ready cycle.
        start(32'd100, 32'd7, 0);
        tick(W);
        start(32'd20, 32'd4, 0);
        drain();

        // Randomized operands, with occasional zero, MIN and -1 corners.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = MINV;
                2: rb = '1;
                3: rb = W'($urandom_range(1, 20));
                4: begin ra = MINV; rb = '1; end
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            start(ra, rb, 0);
            if ($urandom_range(0, 2) == 0) begin
                tick(W);
                continue;
            end
            drain();
            tick($urandom_range(0, 3));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
